// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched: drives one shared neuron datapath across a layer.
// Streams weight/bias reads from a synchronous ROM (one neuron per cycle).
// A tag pipeline tracks which neuron each datapath output belongs to.
// Each result is written to a result RAM, and the arg-max neuron is tracked.
//
// Handshake: there is no back-pressure. mem_rd is a one-cycle read strobe, and
// ROM data is consumed exactly one cycle later. y_we qualifies y_addr/y_data
// for exactly one cycle per neuron. done qualifies best_idx/best_y, which then
// hold until the next accepted start.
module neuron_layer_sched #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = 3,
  parameter int PIPE_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [16:0]       x_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [16:0]       mem_w,
  input  logic [16:0]       mem_b,
  output logic [16:0]       n_x,
  output logic [16:0]       n_w,
  output logic [16:0]       n_bias,
  input  logic [16:0]       n_y,
  output logic              y_we,
  output logic [ADDR_W-1:0] y_addr,
  output logic [16:0]       y_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] best_idx,
  output logic [16:0]       best_y
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            cnt;
  logic [PIPE_LAT:0]            tag_v;
  logic [PIPE_LAT:0][ADDR_W-1:0] tag_i;
  logic                         tag_out_v;
  logic [ADDR_W-1:0]            tag_out_i;
  logic                         last_wr;
  logic                         accept;
  logic                         kill;

  assign tag_out_v = tag_v[PIPE_LAT];
  assign tag_out_i = tag_i[PIPE_LAT];
  assign last_wr   = tag_out_v && (tag_out_i == LAST_IDX);
  assign accept    = (state == IDLE) && start;
  assign kill      = (state != IDLE) && abort;

  // The weight and bias go straight from the ROM to the datapath.
  assign n_w    = mem_w;
  assign n_bias = mem_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort beats every other transition outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (abort) state_nxt = IDLE;
               else if (cnt == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (abort || last_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; address and data buses are zero when their strobe is low
  always_comb begin
    mem_rd   = (state == ISSUE);
    mem_addr = mem_rd ? cnt : '0;
    busy     = (state != IDLE);
    y_we     = tag_out_v;
    y_addr   = tag_out_v ? tag_out_i : '0;
    y_data   = tag_out_v ? n_y : '0;
  end

  // Issue counter, held layer input, done pulse and arg-max tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      n_x      <= '0;
      done     <= 1'b0;
      best_idx <= '0;
      best_y   <= '0;
    end else begin
      done <= (state == DRAIN) && last_wr && !abort;
      if (state == ISSUE) cnt <= cnt + 1'b1;
      // A strict compare keeps the lower index on a tie.
      if (tag_out_v && (n_y > best_y)) begin
        best_y   <= n_y;
        best_idx <= tag_out_i;
      end
      if (accept) begin
        n_x      <= x_in;
        cnt      <= '0;
        best_y   <= '0;
        best_idx <= '0;
      end
    end
  end

  // Tag pipeline that lines up each neuron index with its datapath output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_i <= '0;
    end else if (kill) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= mem_rd;
      tag_i[0] <= cnt;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Testbench for neuron_layer_sched.
// The bench provides a synchronous ROM model and a stand-in neuron datapath.
// A driver issues layer passes, and a reference model predicts results.
// A scoreboard queue holds the expected writes and done events, tagged with
// the cycle in which each one must appear.
module tb_neuron_layer_sched;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int PL = 4;
  localparam int EW = 16 + AW + 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (defaults) ----------------
  logic          start = 1'b0, abort = 1'b0;
  logic [16:0]   x_in = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [16:0]   mem_w, mem_b, n_x, n_w, n_bias, n_y, y_data, best_y;
  logic          y_we, busy, done;
  logic [AW-1:0] y_addr, best_idx;

  neuron_layer_sched #(.N_NEURONS(N), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_w(mem_w), .mem_b(mem_b),
    .n_x(n_x), .n_w(n_w), .n_bias(n_bias), .n_y(n_y),
    .y_we(y_we), .y_addr(y_addr), .y_data(y_data), .busy(busy), .done(done),
    .best_idx(best_idx), .best_y(best_y)
  );

  // Stand-in neuron function: a fixed-point product plus bias, kept unsigned.
  function automatic logic [16:0] nf(input logic [16:0] x, input logic [16:0] w,
                                     input logic [16:0] b);
    logic [33:0] p;
    p = {17'b0, x} * {17'b0, w};
    p = (p >> 16) + {17'b0, b};
    return p[16:0];
  endfunction

  // ROM model: the data for a read appears on the next cycle.
  logic [16:0] rom_w [N];
  logic [16:0] rom_b [N];
  logic [16:0] rom_q_w = '0, rom_q_b = '0;
  always @(posedge clk) if (mem_rd) begin
    rom_q_w <= rom_w[mem_addr];
    rom_q_b <= rom_b[mem_addr];
  end
  assign mem_w = rom_q_w;
  assign mem_b = rom_q_b;

  // Neuron datapath model: the output appears PL cycles after its inputs.
  logic [16:0] ny_pipe [PL];
  initial for (int i = 0; i < PL; i++) ny_pipe[i] = '0;
  always @(posedge clk) begin
    ny_pipe[0] <= nf(n_x, n_w, n_bias);
    for (int i = 1; i < PL; i++) ny_pipe[i] <= ny_pipe[i-1];
  end
  assign n_y = ny_pipe[PL-1];

  // ---------------- small DUT: N=2, PIPE_LAT=1 ----------------
  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [16:0] x2 = 17'h0C000;
  logic [0:0]  mem_addr2, y_addr2, best_idx2;
  logic        mem_rd2, y_we2, busy2, done2;
  logic [16:0] mem_w2, mem_b2, n_x2, n_w2, n_b2, n_y2, y_data2, best_y2;
  logic [16:0] rom2_w [2];
  logic [16:0] rom2_b [2];
  logic [16:0] rom2_qw = '0, rom2_qb = '0, ny2_q = '0;

  neuron_layer_sched #(.N_NEURONS(2), .ADDR_W(1), .PIPE_LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .x_in(x2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_w(mem_w2), .mem_b(mem_b2),
    .n_x(n_x2), .n_w(n_w2), .n_bias(n_b2), .n_y(n_y2),
    .y_we(y_we2), .y_addr(y_addr2), .y_data(y_data2), .busy(busy2), .done(done2),
    .best_idx(best_idx2), .best_y(best_y2)
  );

  initial begin
    rom2_w[0] = 17'h03000; rom2_b[0] = 17'h00100;
    rom2_w[1] = 17'h01000; rom2_b[1] = 17'h00020;
  end
  always @(posedge clk) begin
    if (mem_rd2) begin
      rom2_qw <= rom2_w[mem_addr2];
      rom2_qb <= rom2_b[mem_addr2];
    end
    ny2_q <= nf(n_x2, n_w2, n_b2);
  end
  assign mem_w2 = rom2_qw;
  assign mem_b2 = rom2_qb;
  assign n_y2   = ny2_q;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model. It predicts the layer pass from the layer description
  // alone: neuron k's output is nf(x, w_k, b_k). The output is written at
  // start + k + 2 + PL. The winner is the first index holding the maximum.
  // The done pulse comes at start + N + 2 + PL.
  task automatic push_pass(input int c0, input logic [16:0] x, input int n_wr,
                           input bit with_done);
    logic [16:0]   y;
    logic [16:0]   by;
    logic [AW-1:0] bi;
    by = '0;
    bi = '0;
    for (int k = 0; k < N; k++) begin
      y = nf(x, rom_w[k], rom_b[k]);
      if (k < n_wr) exp_q.push_back({16'(c0 + k + 2 + PL), AW'(k), y});
      if (y > by) begin
        by = y;
        bi = AW'(k);
      end
    end
    if (with_done) exp_done_q.push_back({16'(c0 + N + 2 + PL), bi, by});
  endtask

  // Monitor: pops the next expectation whenever the DUT presents a write or done.
  always @(negedge clk) if (rst_n) begin
    if (y_we) begin
      if (exp_q.size() == 0) chk("unexpected_y_we", {cyc[15:0], y_addr, y_data}, '0);
      else chk("y_write{cycle,addr,data}", {cyc[15:0], y_addr, y_data}, exp_q.pop_front());
    end
    if (done) begin
      if (exp_done_q.size() == 0) chk("unexpected_done", {cyc[15:0], best_idx, best_y}, '0);
      else chk("done{cycle,best_idx,best_y}", {cyc[15:0], best_idx, best_y},
               exp_done_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    idle_cycles(N + PL + 4);
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 0);
    chk({name, "_pending_done"}, 64'(exp_done_q.size()), 0);
    chk({name, "_busy_after"}, 64'(busy), 0);
  endtask

  task automatic load_rom_random();
    for (int k = 0; k < N; k++) begin
      rom_w[k] = 17'($urandom_range(0, 17'h1FFFF));
      rom_b[k] = 17'($urandom_range(0, 17'h03FFF));
    end
  endtask

  // mode 0: plain pass; 1: abort together with start in IDLE; 2: stray start mid-pass
  task automatic run_pass(input logic [16:0] x, input int mode, input string name);
    int c0;
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    abort = (mode == 1);
    c0    = cyc;
    push_pass(c0, x, N, 1'b1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    x_in  = 17'($urandom);
    if (mode == 2) begin
      idle_cycles(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check_drained(name);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
    chk({tag, "_n_x"}, 64'(n_x), 0);
    chk({tag, "_y_we"}, 64'(y_we), 0);
    chk({tag, "_y_addr"}, 64'(y_addr), 0);
    chk({tag, "_y_data"}, 64'(y_data), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_best_idx"}, 64'(best_idx), 0);
    chk({tag, "_best_y"}, 64'(best_y), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int c0;
    int rel;
    logic [16:0] x_a, x_b;

    for (int k = 0; k < N; k++) begin
      rom_w[k] = 17'(k * 17'h01000);
      rom_b[k] = '0;
    end
    idle_cycles(3);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // Ascending weights with x = 0.5: the last neuron wins.
    run_pass(17'h08000, 0, "ramp");

    // Random layers, including the stray-start and start+abort variants.
    for (int p = 0; p < 6; p++) begin
      load_rom_random();
      run_pass(17'($urandom), p % 3, "random");
    end

    // An abort pulse in IDLE has no effect.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", 64'(busy), 0);

    // Neurons 2 and 5 tie for the maximum: the lower index wins.
    load_rom_random();
    rom_w[0] = '0; rom_b[0] = '0;
    rom_w[1] = '0; rom_b[1] = '0;
    begin
      int m;
      logic [16:0] mv;
      m  = 2;
      mv = '0;
      for (int k = 2; k < N; k++)
        if (nf(17'h10000, rom_w[k], rom_b[k]) > mv) begin
          mv = nf(17'h10000, rom_w[k], rom_b[k]);
          m  = k;
        end
      rom_w[2] = rom_w[m]; rom_b[2] = rom_b[m];
      rom_w[5] = rom_w[m]; rom_b[5] = rom_b[m];
    end
    run_pass(17'h10000, 0, "tie");

    // Abort at cycle 5, then restart at cycle 6.
    load_rom_random();
    @(negedge clk);
    start = 1'b1;
    x_in  = 17'h05555;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_c6", 64'(busy), 0);
    chk("abort_mem_rd_c6", 64'(mem_rd), 0);
    start = 1'b1;
    x_in  = 17'h0A0A0;
    push_pass(cyc, 17'h0A0A0, N, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_drained("after_abort");

    // Start held high: it is re-accepted at the done cycle.
    load_rom_random();
    x_a = 17'($urandom);
    x_b = 17'($urandom);
    @(negedge clk);
    start = 1'b1;
    x_in  = x_a;
    c0    = cyc;
    push_pass(c0, x_a, N, 1'b1);
    push_pass(c0 + N + 2 + PL, x_b, N, 1'b1);
    @(negedge clk);
    x_in = x_b;
    while (cyc < c0 + N + 3 + PL) @(negedge clk);
    chk("held_start_mem_rd", 64'(mem_rd), 1);
    chk("held_start_mem_addr", 64'(mem_addr), 0);
    start = 1'b0;
    check_drained("held_start");

    // A one-cycle reset pulse at cycle 9 of a pass.
    load_rom_random();
    @(negedge clk);
    start = 1'b1;
    x_in  = 17'h0FFFF;
    c0    = cyc;
    push_pass(c0, 17'h0FFFF, 9 - 2 - PL, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 8) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midpass_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_drained("midpass_reset");

    // Small configuration: N=2, PIPE_LAT=1.
    @(negedge clk);
    start2 = 1'b1;
    c0     = cyc;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      rel = cyc - c0;
      chk("small_y_we", 64'(y_we2), 64'((rel == 3) || (rel == 4)));
      chk("small_done", 64'(done2), 64'(rel == 5));
      if (rel == 3 || rel == 4) begin
        chk("small_y_addr", 64'(y_addr2), 64'(rel - 3));
        chk("small_y_data", 64'(y_data2), 64'(nf(x2, rom2_w[rel-3], rom2_b[rel-3])));
      end
      if (rel == 5) chk("small_best_idx", 64'(best_idx2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_layer_sched.md
# neuron_layer_sched

Sequencer that time-multiplexes one `neuron_1warstwy` datapath across a layer of `N_NEURONS` neurons. The layer shares a single input sample `x`. Weights and biases come from an external synchronous ROM, one neuron per clock, and the datapath pipeline is kept full. Each neuron output is written to a result RAM as it emerges. The block also tracks the arg-max neuron for the classifier stage downstream.

## Interface
- `N_NEURONS`, default 8: neurons per layer, range 2..256.
- `ADDR_W`, default 3: address width; must satisfy 2^ADDR_W >= N_NEURONS.
- `PIPE_LAT`, default 4: cycles from `n_x`/`n_w`/`n_bias` to the matching `n_y` in the neuron datapath (mul 1, adder 1, LUT index 1, LUT 1).
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous reset, active low.
- `start`, in, 1: begin a layer pass; sampled only in IDLE.
- `abort`, in, 1: cancel the pass in progress.
- `x_in`, in, 17: layer input, s16f; captured on an accepted `start`.
- `mem_addr`, out, ADDR_W: weight/bias ROM address.
- `mem_rd`, out, 1: ROM read strobe; ROM data is valid on the next cycle.
- `mem_w`, in, 17: weight, s4i12f.
- `mem_b`, in, 17: bias, s4i12f.
- `n_x`, out, 17: to neuron `x`.
- `n_w`, out, 17: to neuron `w`.
- `n_bias`, out, 17: to neuron `bias`.
- `n_y`, in, 17: from neuron `y`, unsigned 16f.
- `y_we`, out, 1: result RAM write enable.
- `y_addr`, out, ADDR_W: result RAM address.
- `y_data`, out, 17: result RAM data.
- `busy`, out, 1: pass in progress.
- `done`, out, 1: one-cycle pulse at the end of a completed pass.
- `best_idx`, out, ADDR_W: index of the largest `n_y` in the last completed pass.
- `best_y`, out, 17: value of that largest `n_y`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE to ISSUE on `start`. On entry, `n_x` <= `x_in`, the issue counter is cleared, and `best_y`/`best_idx` are cleared.
- ISSUE:
  - `mem_rd`=1 and `mem_addr`=k, for k = 0..N_NEURONS-1, one value per cycle.
  - After issuing k = N_NEURONS-1, go to DRAIN.
- `n_w` and `n_bias` are combinational pass-throughs of `mem_w` and `mem_b`.
- `n_x` is held constant for the whole pass.
- Tag pipeline: a valid bit plus index, 1+PIPE_LAT stages deep, loaded in the cycle `mem_rd` is asserted.
- When the tag pipeline output is valid:
  - `y_we`=1, `y_addr`=tag index, `y_data`=`n_y`.
  - If `n_y` > `best_y` (unsigned, strict), update `best_y` and `best_idx`. On a tie, the lower index is kept.
- DRAIN to IDLE once the last tag has been written. `done`=1 in the first IDLE cycle.
- `start` asserted in the same cycle as `done` is accepted.
- `abort` (any state other than IDLE):
  - Next state is IDLE and all tag valid bits are cleared.
  - No further `y_we`; `done` is not pulsed.
  - `best_*` keeps the partial values and must not be trusted.
- `start` while busy: ignored. `abort` in IDLE: ignored.
- If `start` and `abort` are both high in IDLE: `start` wins.
- Reset values: all outputs 0, state IDLE, tag pipeline cleared.
- An asynchronous reset mid-pass behaves like `abort`, and additionally zeroes `n_x`, `best_y` and `best_idx`.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..N: `mem_rd`=1, `mem_addr`=cycle-1; `busy`=1 from cycle 1.
- Neuron k inputs are valid at cycle k+2.
- `y_we` for neuron k is at cycle k+2+PIPE_LAT.
- `done` and `busy`=0 at cycle N+2+PIPE_LAT. With the defaults this is cycle 14; the last `y_we` is at cycle 13.
- Throughput: one neuron per clock. Pass length is N+2+PIPE_LAT cycles from start to done.
- `best_idx`/`best_y` are stable and valid from the `done` cycle until the next accepted `start`.

## Test plan
- Defaults; `mem_w`=k·0x1000 (weight k.0); `x_in`=0x08000 (0.5); `mem_b`=0.
  - `y_we` at cycles 6..13, `y_addr` 0..7.
  - `y_data` equals the neuron model output.
  - `done` at cycle 14; `best_idx`=7.
- ROM programmed so neurons 2 and 5 give an identical maximum `n_y` -> `best_idx`=2.
- `abort` at cycle 5 -> no `y_we` from cycle 6 on, no `done`, `busy`=0 at cycle 6. A new `start` at cycle 6 then completes normally.
- `start` held high through a pass -> `start` re-accepted at the `done` cycle, and `mem_rd` resumes on the next cycle.
- `rst_n` low for 1 cycle at cycle 9 -> all outputs 0 immediately, no further `y_we`, IDLE.
- N_NEURONS=2, PIPE_LAT=1 -> `y_we` at cycles 3 and 4, `done` at cycle 5.
